// File: rtl/bit_packer_pkg.sv
// Shared constants and helpers for the serial-to-parallel bit packer.
package bit_packer_pkg;

  localparam int DEF_WIDTH = 3;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_packer_if.sv
// Bit-in / word-out handshake bundle; master is the source+consumer side, slave is the packer.
interface bit_packer_if
  import bit_packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             sync;
  logic [WIDTH-1:0] outv;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_bit, in_valid, sync, out_ready,
    input  in_ready, outv, out_valid
  );

  modport slave (
    input  in_bit, in_valid, sync, out_ready,
    output in_ready, outv, out_valid
  );

endinterface

// File: rtl/bit_packer.sv
// Collects one bit per accepted cycle into a WIDTH-bit word and presents it through
// a single holding register, so the next word can assemble while the consumer stalls.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  bit_packer_if.slave              bus,
  output logic [cnt_w(WIDTH)-1:0]  bit_cnt
);

  localparam int            CW    = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam bit_order_e    ORDER = bit_order_e'(MSB_FIRST);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] outv_q, outv_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready, acc, at_last, complete;

  // Word position of the idx-th accepted bit.
  function automatic logic [CW-1:0] slot(input logic [CW-1:0] idx);
    return (ORDER == ORDER_MSB_FIRST) ? LAST - idx : idx;
  endfunction

  // Only the final bit of a word can be refused, and only while the held word stalls.
  assign at_last  = (cnt_q == LAST);
  assign in_ready = !(at_last && out_valid_q && !bus.out_ready);
  assign acc      = bus.in_valid && in_ready;
  assign complete = acc && at_last && !bus.sync;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (bus.sync) begin
      cnt_d = '0;
      sh_d  = '0;
      if (acc) begin
        sh_d[slot('0)] = bus.in_bit;
        cnt_d          = CW'(1);
      end
    end else if (acc) begin
      if (at_last) begin
        cnt_d = '0;
        sh_d  = '0;
      end else begin
        sh_d[slot(cnt_q)] = bus.in_bit;
        cnt_d             = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    outv_d      = outv_q;
    out_valid_d = out_valid_q;
    if (complete) begin
      outv_d             = sh_q;
      outv_d[slot(LAST)] = bus.in_bit;
      out_valid_d        = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: reset is tested inside the clocked branch, so it is synchronous and stays out of the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outv_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      outv_q      <= outv_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.outv      = outv_q;
  assign bus.out_valid = out_valid_q;
  assign bit_cnt       = cnt_q;

endmodule
